// File: rtl/vc_msg_serializer_pkg.sv
// Shared definitions for the message serializer and its matching deserializer.
package vc_msg_serializer_pkg;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/vc_msg_serializer_ctrl.sv
// Serializer control: IDLE/SEND FSM, beat index counter, last-beat compare and handshakes.
//   state    | meaning
//   SER_IDLE | no message held, in_rdy high
//   SER_SEND | emitting beat idx of the held message
module vc_msg_serializer_ctrl
  import vc_msg_serializer_pkg::*;
#(
  parameter int p_num_beats = 4,
  parameter int c_idx_nbits = $clog2(p_num_beats)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  input  logic [c_idx_nbits-1:0] in_nbeats_m1,
  input  logic                   out_rdy,
  output logic                   in_rdy,
  output logic                   out_val,
  output logic                   out_last,
  output logic                   load,
  output logic [c_idx_nbits-1:0] idx
);

  ser_state_e             state_q, state_d;
  logic [c_idx_nbits-1:0] last_q;
  logic [c_idx_nbits-1:0] last_d;
  logic                   out_go;

  assign out_val  = (state_q == SER_SEND);
  assign out_last = out_val && (idx == last_q);
  assign out_go   = out_val && out_rdy;
  // Pipe behaviour: the final beat's acceptance frees the slot in the same cycle.
  assign in_rdy   = reset && ((state_q == SER_IDLE) || (out_last && out_rdy));
  assign load     = in_val && in_rdy;

  // Out-of-range lengths are clamped so the index never leaves the message.
  assign last_d = (32'(in_nbeats_m1) >= p_num_beats) ? c_idx_nbits'(p_num_beats - 1)
                                                      : in_nbeats_m1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE: if (load) state_d = SER_SEND;
      SER_SEND: if (out_go && out_last && !load) state_d = SER_IDLE;
      default:  state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SER_IDLE;
      idx     <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        idx    <= '0;
        last_q <= last_d;
      end else if (out_go && !out_last) begin
        idx <= idx + 1'b1;
      end
    end
  end

  a_ctrl_known: assert property (@(posedge clk) disable iff (!reset)
    !$isunknown({in_val, out_rdy, in_nbeats_m1}));
  a_len_legal: assert property (@(posedge clk) disable iff (!reset)
    load |-> (32'(in_nbeats_m1) < p_num_beats));
  a_nbeats_stable: assert property (@(posedge clk) disable iff (!reset)
    (in_val && !in_rdy) |=> (!in_val || $stable(in_nbeats_m1)));

endmodule

// File: rtl/vc_msg_serializer.sv
// Wide-to-narrow serializer: one message per input handshake, emitted LSB beat first.
module vc_msg_serializer
  import vc_msg_serializer_pkg::*;
#(
  parameter int p_out_nbits = 8,
  parameter int p_num_beats = 4,
  parameter int p_in_nbits  = p_out_nbits * p_num_beats,
  parameter int c_idx_nbits = $clog2(p_num_beats)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_in_nbits-1:0]  in_msg,
  input  logic [c_idx_nbits-1:0] in_nbeats_m1,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_out_nbits-1:0] out_msg,
  output logic                   out_last
);

  logic                                     load;
  logic [c_idx_nbits-1:0]                   idx;
  logic [p_num_beats-1:0][p_out_nbits-1:0]  msg_q;

  vc_msg_serializer_ctrl #(
    .p_num_beats (p_num_beats),
    .c_idx_nbits (c_idx_nbits)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .in_val       (in_val),
    .in_nbeats_m1 (in_nbeats_m1),
    .out_rdy      (out_rdy),
    .in_rdy       (in_rdy),
    .out_val      (out_val),
    .out_last     (out_last),
    .load         (load),
    .idx          (idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    msg_q <= '0;
    else if (load) msg_q <= in_msg;
  end

  // Gated so a stale beat never shows while idle.
  assign out_msg = out_val ? msg_q[idx] : '0;

  a_msg_stable: assert property (@(posedge clk) disable iff (!reset)
    (in_val && !in_rdy) |=> (!in_val || $stable(in_msg)));

endmodule
